// File: rtl/lna_ctrl.sv
// LNA bias controller: CPU register file (PD/MODE/SETTLE/STATUS) plus one OFF/SETTLE/ON FSM per channel.
// Optional macro LNA_CTRL_RAMP_EN makes mode step gradually toward the target while a channel is ON.
module lna_ctrl #(
  parameter int DATA_W   = 32,
  parameter int N_CH     = 4,
  parameter int MODE_W   = 2,
  parameter int SETTLE_W = 8,
  parameter int RAMP_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic [1:0]             address,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   wstrb,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic [N_CH-1:0]        pd,
  output logic [N_CH*MODE_W-1:0] mode,
  output logic [N_CH-1:0]        on
);

  localparam int MW = N_CH * MODE_W;

  // Handshake: a request is the cycle with valid=1; its write lands on that
  // edge, and ready (with rdata for reads) is high for exactly the next cycle.
  // Every valid cycle is a new request, so back-to-back requests are legal.

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2
  } ch_state_t;

  logic [N_CH-1:0]     pd_reg;
  logic [MW-1:0]       target;
  logic [SETTLE_W-1:0] settle_reg;
  logic [DATA_W-1:0]   rd_mux;
  logic [N_CH-1:0]     on_r;
  logic [N_CH-1:0]     busy_r;
  ch_state_t           ch_state [N_CH];
  logic [SETTLE_W-1:0] cnt      [N_CH];
  logic                unused_wdata;

  assign pd = pd_reg;
  assign on = on_r;
  assign unused_wdata = ^wdata;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[N_CH-1:0]     = pd_reg;
      2'd1: rd_mux[MW-1:0]       = target;
      2'd2: rd_mux[SETTLE_W-1:0] = settle_reg;
      default: begin
        rd_mux[N_CH-1:0] = on_r;
        rd_mux[8 +: N_CH] = busy_r;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pd_reg     <= '1;
      target     <= '0;
      settle_reg <= '1;
      ready      <= 1'b0;
      rdata      <= '0;
    end else begin
      ready <= valid;
      if (valid && wstrb) begin
        case (address)
          2'd0: pd_reg     <= wdata[N_CH-1:0];
          2'd1: target     <= wdata[MW-1:0];
          2'd2: settle_reg <= wdata[SETTLE_W-1:0];
          default: ;
        endcase
      end
      if (valid && !wstrb) rdata <= rd_mux;
    end
  end

  // The FSMs read pd_reg/settle_reg before this edge's write lands, so a
  // same-cycle write only takes effect on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_state[i] <= ST_OFF;
        cnt[i]      <= '0;
      end
      on_r   <= '0;
      busy_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case (ch_state[i])
          ST_OFF: begin
            if (!pd_reg[i]) begin
              ch_state[i] <= ST_SETTLE;
              cnt[i]      <= settle_reg;
              busy_r[i]   <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (pd_reg[i]) begin
              ch_state[i] <= ST_OFF;
              busy_r[i]   <= 1'b0;
            end else if (cnt[i] == '0) begin
              ch_state[i] <= ST_ON;
              busy_r[i]   <= 1'b0;
              on_r[i]     <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
          ST_ON: begin
            if (pd_reg[i]) begin
              ch_state[i] <= ST_OFF;
              on_r[i]     <= 1'b0;
            end
          end
          default: begin
            ch_state[i] <= ST_OFF;
            on_r[i]     <= 1'b0;
            busy_r[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LNA_CTRL_RAMP_EN
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [MW-1:0]    mode_r;
  logic [DIV_W-1:0] div_cnt [N_CH];

  assign mode = mode_r;

  // While ON, walk one code per RAMP_DIV cycles; stepping stops on equality, so no overshoot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r <= '0;
      for (int i = 0; i < N_CH; i++) div_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_state[i] != ST_ON) begin
          mode_r[i*MODE_W +: MODE_W] <= target[i*MODE_W +: MODE_W];
          div_cnt[i] <= '0;
        end else if (mode_r[i*MODE_W +: MODE_W] == target[i*MODE_W +: MODE_W]) begin
          div_cnt[i] <= '0;
        end else if (div_cnt[i] == DIV_W'(RAMP_DIV - 1)) begin
          div_cnt[i] <= '0;
          if (mode_r[i*MODE_W +: MODE_W] < target[i*MODE_W +: MODE_W])
            mode_r[i*MODE_W +: MODE_W] <= mode_r[i*MODE_W +: MODE_W] + 1'b1;
          else
            mode_r[i*MODE_W +: MODE_W] <= mode_r[i*MODE_W +: MODE_W] - 1'b1;
        end else begin
          div_cnt[i] <= div_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_ramp;

  assign mode = target;
  assign unused_ramp = (RAMP_DIV > 0);
`endif

endmodule

// File: tb/tb_lna_ctrl.sv
// Directed bench for lna_ctrl: reset state, register access, settle timing,
// power-down override, back-to-back requests, mode update and reset abort.
module tb_lna_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        wstrb = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic [3:0]  pd;
  logic [7:0]  mode;
  logic [3:0]  on;

  int          vec = 0;
  int          errs = 0;
  logic [31:0] rd;

  logic        b2b_wr  [4];
  logic [1:0]  b2b_adr [4];
  logic [31:0] b2b_dat [4];
  logic [31:0] b2b_exp [4];

  lna_ctrl #(
    .DATA_W(32), .N_CH(4), .MODE_W(2), .SETTLE_W(8), .RAMP_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .pd(pd), .mode(mode), .on(on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with ready checked.
  task automatic cpu(input logic wr, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    valid = 1'b1;
    wstrb = wr;
    address = a;
    wdata = d;
    @(negedge clk);
    valid = 1'b0;
    wstrb = 1'b0;
    chk("ready_pulse", {31'd0, ready}, 32'd1);
    r = rdata;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pd", {28'd0, pd}, 32'hF);
    chk("rst_on", {28'd0, on}, 32'h0);
    chk("rst_mode", {24'd0, mode}, 32'h0);
    rst_n = 1'b1;

    cpu(1'b0, 2'd0, 32'd0, rd);
    chk("rd_pd_reset", rd, 32'hF);
    @(negedge clk);
    chk("ready_single", {31'd0, ready}, 32'd0);
    chk("settle_reset", {28'd0, on}, 32'h0);

    cpu(1'b1, 2'd2, 32'd5, rd);
    cpu(1'b0, 2'd2, 32'd0, rd);
    chk("rd_settle", rd, 32'd5);

    // ch0 enters SETTLE one edge after the PD write edge and stays 6 cycles.
    cpu(1'b1, 2'd0, 32'hE, rd);
    chk("pd_after_wr", {28'd0, pd}, 32'hE);
    chk("on_wr_cycle", {28'd0, on}, 32'h0);
    @(negedge clk);
    cpu(1'b0, 2'd3, 32'd0, rd);
    chk("status_busy_early", rd, 32'h100);
    repeat (3) @(negedge clk);
    cpu(1'b0, 2'd3, 32'd0, rd);
    chk("status_busy_last", rd, 32'h100);
    chk("on_last_settle", {28'd0, on}, 32'h0);
    @(negedge clk);
    chk("on_after_settle", {28'd0, on}, 32'h1);
    cpu(1'b0, 2'd3, 32'd0, rd);
    chk("status_on", rd, 32'h001);

    // Power down from ON, then abort a settle in progress.
    cpu(1'b1, 2'd0, 32'hF, rd);
    chk("on_pd_wr_cycle", {28'd0, on}, 32'h1);
    @(negedge clk);
    chk("on_after_pd", {28'd0, on}, 32'h0);
    cpu(1'b1, 2'd0, 32'hE, rd);
    repeat (2) @(negedge clk);
    cpu(1'b1, 2'd0, 32'hF, rd);
    @(negedge clk);
    cpu(1'b0, 2'd3, 32'd0, rd);
    chk("status_abort", rd, 32'h000);
    repeat (10) @(negedge clk);
    chk("on_stay_off", {28'd0, on}, 32'h0);

    // Bring ch1 up with a 3-cycle settle.
    cpu(1'b1, 2'd2, 32'd2, rd);
    cpu(1'b1, 2'd0, 32'hD, rd);
    repeat (6) @(negedge clk);
    cpu(1'b0, 2'd3, 32'd0, rd);
    chk("status_ch1_on", rd, 32'h002);
    chk("on_ch1", {28'd0, on}, 32'h2);

    // Four back-to-back requests: write MODE, read MODE, write STATUS, read STATUS.
    b2b_wr[0] = 1'b1; b2b_adr[0] = 2'd1; b2b_dat[0] = 32'h0C;   b2b_exp[0] = 32'h0;
    b2b_wr[1] = 1'b0; b2b_adr[1] = 2'd1; b2b_dat[1] = 32'h0;    b2b_exp[1] = 32'h0C;
    b2b_wr[2] = 1'b1; b2b_adr[2] = 2'd3; b2b_dat[2] = 32'hFFFF; b2b_exp[2] = 32'h0;
    b2b_wr[3] = 1'b0; b2b_adr[3] = 2'd3; b2b_dat[3] = 32'h0;    b2b_exp[3] = 32'h002;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      wstrb = b2b_wr[k];
      address = b2b_adr[k];
      wdata = b2b_dat[k];
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", k), {31'd0, ready}, 32'd1);
      if (!b2b_wr[k]) chk($sformatf("b2b_rdata%0d", k), rdata, b2b_exp[k]);
`ifdef LNA_CTRL_RAMP_EN
      if (k == 0) chk("mode_ramp_start", {24'd0, mode}, 32'h00);
`else
      if (k == 0) chk("mode_direct", {24'd0, mode}, 32'h0C);
`endif
    end
    valid = 1'b0;
    wstrb = 1'b0;
    @(negedge clk);
    chk("b2b_ready_end", {31'd0, ready}, 32'd0);
`ifdef LNA_CTRL_RAMP_EN
    chk("mode_ramp1", {24'd0, mode}, 32'h04);
    repeat (4) @(negedge clk);
    chk("mode_ramp2", {24'd0, mode}, 32'h08);
    repeat (4) @(negedge clk);
    chk("mode_ramp3", {24'd0, mode}, 32'h0C);
    repeat (8) @(negedge clk);
    chk("mode_ramp_hold", {24'd0, mode}, 32'h0C);
`else
    chk("mode_hold", {24'd0, mode}, 32'h0C);
`endif

    // Reset in the middle of a settle, with a request outstanding on the same edge.
    cpu(1'b1, 2'd2, 32'd9, rd);
    cpu(1'b1, 2'd0, 32'hC, rd);
    repeat (3) @(negedge clk);
    valid = 1'b1;
    wstrb = 1'b0;
    address = 2'd3;
    rst_n = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk("rst2_ready", {31'd0, ready}, 32'd0);
    chk("rst2_rdata", rdata, 32'd0);
    chk("rst2_pd", {28'd0, pd}, 32'hF);
    chk("rst2_on", {28'd0, on}, 32'h0);
    chk("rst2_mode", {24'd0, mode}, 32'h0);
    rst_n = 1'b1;
    cpu(1'b0, 2'd3, 32'd0, rd);
    chk("rst2_status", rd, 32'h000);
    cpu(1'b0, 2'd2, 32'd0, rd);
    chk("rst2_settle", rd, 32'hFF);
    cpu(1'b0, 2'd1, 32'd0, rd);
    chk("rst2_target", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
